wash_sequencer: RTL and testbench

Washing-cycle controller. Steps the machine through fill, wash, drain and spin on a 1 Hz tick. Produces the three 6-bit values the seven-segment display stage consumes: remaining total seconds, remaining seconds in the current stage, and water level. It sits directly upstream of the display block.

---
 rtl/wash_sequencer.sv | 156 +++++++++++++++
 tb/tb_wash_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-cycle controller: steps fill -> wash -> drain -> spin -> done on a 1 Hz tick and
// drives the remaining-time / water-level values for the display stage. Optional macro: WASH_TICK_GEN_EN.
module wash_sequencer #(
    parameter int WAT_MAX  = 10,
    parameter int WASH_T   = 15,
    parameter int SPIN_T   = 8,
    parameter int BUZZ_T   = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       uRst_,
    input  logic       uTick,
    input  logic       uStart,
    input  logic       uStop,
    input  logic       uPause,
    output logic [5:0] yTot,
    output logic [5:0] yCur,
    output logic [5:0] yWat,
    output logic [2:0] yState,
    output logic       yBuzz
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        DRAIN = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [5:0] T0       = 6'(2 * WAT_MAX + WASH_T + SPIN_T);
    localparam logic [5:0] WAT_FULL = 6'(WAT_MAX);
    localparam logic [5:0] WASH_LEN = 6'(WASH_T);
    localparam logic [5:0] SPIN_LEN = 6'(SPIN_T);
    localparam logic [5:0] BUZZ_LEN = 6'(BUZZ_T);
    localparam logic [5:0] ONE      = 6'd1;

    state_t     state;
    logic [5:0] buzzCnt;
    logic       tick;
    logic       startAct;
    logic       stopAct;
    logic       effTick;

`ifdef WASH_TICK_GEN_EN
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] preCnt;
    logic             unusedTick;

    // Restarting the prescaler on uStart makes the first FILL second a full second long.
    always_ff @(posedge clk or negedge uRst_) begin
        if (!uRst_) begin
            preCnt <= '0;
        end else if (uStart || preCnt == DIV_LAST) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + DIV_W'(1);
        end
    end

    assign tick       = (preCnt == DIV_LAST);
    assign unusedTick = uTick;
`else
    logic unusedTickDiv;

    assign tick          = uTick;
    assign unusedTickDiv = ^32'(TICK_DIV);
`endif

    assign startAct = uStart && (state == IDLE || state == DONE);
    assign stopAct  = uStop && (state == FILL || state == WASH);
    // A tick that coincides with an honoured start/stop is swallowed by that action.
    assign effTick  = tick && !uPause && !startAct && !stopAct;
    assign yState   = state;

    always_ff @(posedge clk or negedge uRst_) begin
        if (!uRst_) begin
            state   <= IDLE;
            yTot    <= T0;
            yCur    <= '0;
            yWat    <= '0;
            yBuzz   <= 1'b0;
            buzzCnt <= '0;
        end else if (startAct) begin
            state   <= FILL;
            yTot    <= T0;
            yCur    <= WAT_FULL;
            yWat    <= '0;
            yBuzz   <= 1'b0;
            buzzCnt <= '0;
        end else if (stopAct) begin
            if (yWat == '0) begin
                state <= SPIN;
                yCur  <= SPIN_LEN;
                yTot  <= SPIN_LEN;
            end else begin
                state <= DRAIN;
                yCur  <= yWat;
                yTot  <= yWat + SPIN_LEN;
            end
        end else if (effTick) begin
            case (state)
                FILL, WASH, DRAIN, SPIN: begin
                    yTot <= yTot - ONE;
                    if (yCur != ONE) begin
                        yCur <= yCur - ONE;
                        if (state == FILL) begin
                            yWat <= yWat + ONE;
                        end else if (state == DRAIN) begin
                            yWat <= yWat - ONE;
                        end
                    end else begin
                        // Next stage duration loads on the same edge, so yCur never shows 0 mid-cycle.
                        case (state)
                            FILL: begin
                                state <= WASH;
                                yCur  <= WASH_LEN;
                                yWat  <= WAT_FULL;
                            end
                            WASH: begin
                                state <= DRAIN;
                                yCur  <= WAT_FULL;
                            end
                            DRAIN: begin
                                state <= SPIN;
                                yCur  <= SPIN_LEN;
                                yWat  <= '0;
                            end
                            default: begin
                                state   <= DONE;
                                yTot    <= '0;
                                yCur    <= '0;
                                yBuzz   <= 1'b1;
                                buzzCnt <= BUZZ_LEN;
                            end
                        endcase
                    end
                end
                DONE: begin
                    buzzCnt <= buzzCnt - ONE;
                    if (buzzCnt == ONE) begin
                        state <= IDLE;
                        yBuzz <= 1'b0;
                        yTot  <= T0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: a vector table plus hand-written sequences, checked through an
// expected-value queue that is filled when stimulus is driven and drained after each edge.
module tb_wash_sequencer;

    logic       clk    = 1'b0;
    logic       uRst_  = 1'b0;
    logic       uTick  = 1'b0;
    logic       uStart = 1'b0;
    logic       uStop  = 1'b0;
    logic       uPause = 1'b0;
    logic [5:0] yTot;
    logic [5:0] yCur;
    logic [5:0] yWat;
    logic [2:0] yState;
    logic       yBuzz;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [2:0] st;
        logic [5:0] tot;
        logic [5:0] cur;
        logic [5:0] wat;
        logic       buzz;
    } exp_t;

    typedef struct {
        logic start;
        logic stop;
        logic pause;
        logic tick;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    wash_sequencer dut (
        .clk   (clk),
        .uRst_ (uRst_),
        .uTick (uTick),
        .uStart(uStart),
        .uStop (uStop),
        .uPause(uPause),
        .yTot  (yTot),
        .yCur  (yCur),
        .yWat  (yWat),
        .yState(yState),
        .yBuzz (yBuzz)
    );

    function automatic exp_t mk(input int st, input int tot, input int cur, input int wat, input int bz);
        exp_t e;
        e.st   = 3'(st);
        e.tot  = 6'(tot);
        e.cur  = 6'(cur);
        e.wat  = 6'(wat);
        e.buzz = 1'(bz);
        return e;
    endfunction

    function automatic void add(input logic s, input logic sp, input logic p, input logic t,
                                input int st, input int tot, input int cur, input int wat, input int bz);
        vec_t v;
        v.start = s;
        v.stop  = sp;
        v.pause = p;
        v.tick  = t;
        v.e     = mk(st, tot, cur, wat, bz);
        vecs.push_back(v);
    endfunction

    // Expected outputs after the k-th tick of an undisturbed cycle, by elapsed-time windows.
    function automatic exp_t timeline(input int k);
        if (k < 10)       return mk(1, 43 - k, 10 - k, k, 0);
        else if (k < 25)  return mk(2, 43 - k, 25 - k, 10, 0);
        else if (k < 35)  return mk(3, 43 - k, 35 - k, 35 - k, 0);
        else if (k < 43)  return mk(4, 43 - k, 43 - k, 0, 0);
        else              return mk(5, 0, 0, 0, 1);
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void compareOut(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".yState"}, int'(yState), int'(e.st));
        chk({tag, ".yTot"},   int'(yTot),   int'(e.tot));
        chk({tag, ".yCur"},   int'(yCur),   int'(e.cur));
        chk({tag, ".yWat"},   int'(yWat),   int'(e.wat));
        chk({tag, ".yBuzz"},  int'(yBuzz),  int'(e.buzz));
    endfunction

    task automatic step(input logic s, input logic sp, input logic p, input logic t,
                        input exp_t e, input string tag);
        uStart = s;
        uStop  = sp;
        uPause = p;
        uTick  = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        uStart = 1'b0;
        uStop  = 1'b0;
        uTick  = 1'b0;
        uPause = 1'b0;
        compareOut(tag);
    endtask

    task automatic tickTo(input exp_t e, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b1, e, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        // Table: full cycle with pause, ignored starts/stops, stop+tick in WASH and DRAIN.
        add(1, 0, 0, 1, 1, 43, 10, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 1, 1, 43 - k, 10 - k, k, 0);
        add(0, 0, 0, 1, 2, 33, 15, 10, 0);
        for (int k = 1; k <= 3; k++) add(0, 0, 0, 1, 2, 33 - k, 15 - k, 10, 0);
        for (int k = 1; k <= 5; k++) add(0, 0, 1, 1, 2, 30, 12, 10, 0);
        add(0, 0, 0, 1, 2, 29, 11, 10, 0);
        add(1, 0, 0, 1, 2, 28, 10, 10, 0);
        add(0, 1, 0, 1, 3, 18, 10, 10, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 1, 3, 18 - k, 10 - k, 10 - k, 0);
        add(0, 1, 0, 1, 4, 8, 8, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 1, 4, 8 - k, 8 - k, 0, 0);
        add(1, 0, 0, 0, 4, 1, 1, 0, 0);
        add(0, 0, 0, 1, 5, 0, 0, 0, 1);
        add(0, 0, 0, 0, 5, 0, 0, 0, 1);
        add(0, 1, 0, 1, 5, 0, 0, 0, 1);
        add(0, 0, 1, 1, 5, 0, 0, 0, 1);
        add(0, 0, 0, 1, 5, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 43, 0, 0, 0);
        add(0, 0, 0, 1, 0, 43, 0, 0, 0);
        add(0, 1, 0, 0, 0, 43, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(0, 43, 0, 0, 0));
        compareOut("reset");
        uRst_ = 1'b1;
        step(0, 0, 0, 0, mk(0, 43, 0, 0, 0), "idle");

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].tick, vecs[i].e,
                 $sformatf("vec%0d", i));
        end

        // Stop after 4 FILL ticks, drain what was filled, then spin and a start in DONE.
        step(1, 0, 0, 0, mk(1, 43, 10, 0, 0), "stopFill.start");
        for (int k = 1; k <= 4; k++) tickTo(mk(1, 43 - k, 10 - k, k, 0), $sformatf("stopFill.fill%0d", k));
        step(0, 1, 0, 0, mk(3, 12, 4, 4, 0), "stopFill.stop");
        for (int k = 1; k <= 3; k++) tickTo(mk(3, 12 - k, 4 - k, 4 - k, 0), $sformatf("stopFill.drain%0d", k));
        tickTo(mk(4, 8, 8, 0, 0), "stopFill.toSpin");
        for (int k = 1; k <= 7; k++) tickTo(mk(4, 8 - k, 8 - k, 0, 0), $sformatf("stopFill.spin%0d", k));
        tickTo(mk(5, 0, 0, 0, 1), "stopFill.done");
        step(1, 0, 0, 1, mk(1, 43, 10, 0, 0), "startInDone");

        // Stop with an empty drum skips DRAIN.
        step(0, 1, 0, 0, mk(4, 8, 8, 0, 0), "stopEmpty");
        for (int k = 1; k <= 7; k++) tickTo(mk(4, 8 - k, 8 - k, 0, 0), $sformatf("stopEmpty.spin%0d", k));
        tickTo(mk(5, 0, 0, 0, 1), "stopEmpty.done");
        for (int k = 1; k <= 2; k++) tickTo(mk(5, 0, 0, 0, 1), $sformatf("stopEmpty.buzz%0d", k));
        tickTo(mk(0, 43, 0, 0, 0), "stopEmpty.idle");

        // Undisturbed 43-tick cycle, then the buzzer window.
        step(1, 0, 0, 0, mk(1, 43, 10, 0, 0), "full.start");
        for (int k = 1; k <= 43; k++) tickTo(timeline(k), $sformatf("full.t%0d", k));
        for (int k = 1; k <= 2; k++) tickTo(mk(5, 0, 0, 0, 1), $sformatf("full.buzz%0d", k));
        tickTo(mk(0, 43, 0, 0, 0), "full.idle");

        // Start while paused stays frozen in FILL; stop while paused is still honoured.
        step(1, 0, 1, 1, mk(1, 43, 10, 0, 0), "pausedStart");
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 1, mk(1, 43, 10, 0, 0), $sformatf("pausedFill%0d", k));
        step(0, 1, 1, 1, mk(4, 8, 8, 0, 0), "pausedStop");

        // Synchronous-looking reset back to IDLE, then start+stop+tick together in IDLE.
        uRst_ = 1'b0;
        #1;
        sb.push_back(mk(0, 43, 0, 0, 0));
        compareOut("resetInSpin");
        uRst_ = 1'b1;
        step(1, 1, 0, 1, mk(1, 43, 10, 0, 0), "startStopIdle");
        for (int k = 1; k <= 11; k++) tickTo(timeline(k), $sformatf("rstRun.t%0d", k));

        // Async reset mid-WASH, between edges, held across an edge with a start pulse.
        #2;
        uRst_ = 1'b0;
        #1;
        sb.push_back(mk(0, 43, 0, 0, 0));
        compareOut("asyncRst");
        uStart = 1'b1;
        uTick  = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(0, 43, 0, 0, 0));
        compareOut("rstHeld");
        uStart = 1'b0;
        uTick  = 1'b0;
        uRst_  = 1'b1;
        step(0, 0, 0, 1, mk(0, 43, 0, 0, 0), "afterRst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
